uart_rx_edge_sampler: RTL and testbench

Oversampling front end of the UART receiver, directly upstream of the RX control FSM. It counts oversampling edges and bit positions within a frame and produces `edge_cnt`/`bit_cnt` for the FSM. It recovers each serial bit by 3-sample majority vote at mid-bit and feeds `sampled_bit` to the start/parity/stop checkers and the deserializer.

---
 rtl/uart_rx_pkg.sv | 15 +
 rtl/uart_rx_edge_bit_counter.sv | 46 ++++
 rtl/uart_rx_edge_sampler.sv | 81 ++++++++
 tb/tb_uart_rx_edge_sampler.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared UART receiver constants: default widths, frame bit indices and the 3-sample vote.
package uart_rx_pkg;
    localparam int PRESCALE_W  = 6;
    localparam int BIT_CNT_W   = 4;
    localparam int DATA_BITS   = 8;

    localparam int BIT_START   = 0;
    localparam int BIT_PAR     = 9;
    localparam int BIT_STOP_NP = 9;
    localparam int BIT_STOP_P  = 10;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction
endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// Edge-within-bit and bit-within-frame counters for the UART receiver.
// Outputs registered, one cycle after the causing condition; no backpressure, counts while enabled.
module uart_rx_edge_bit_counter #(
    parameter int PRESCALE_W = uart_rx_pkg::PRESCALE_W,
    parameter int BIT_CNT_W  = uart_rx_pkg::BIT_CNT_W,
    parameter int DATA_BITS  = uart_rx_pkg::DATA_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable_count,
    input  logic                  PAR_EN,
    input  logic [PRESCALE_W-1:0] PRESCALE,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [BIT_CNT_W-1:0]  bit_cnt
);
    import uart_rx_pkg::*;

    logic [PRESCALE_W-1:0] term_edge;
    logic [BIT_CNT_W-1:0]  last_bit;
    logic                  at_term;
    logic                  at_last;

    assign term_edge = PRESCALE - 1'b1;
    assign last_bit  = BIT_CNT_W'(DATA_BITS + 1) + BIT_CNT_W'(PAR_EN);

    // Greater-or-equal lets a counter stranded past a shrunken PRESCALE wrap at once.
    assign at_term = (edge_cnt >= term_edge);
    assign at_last = (bit_cnt >= last_bit);

    always_ff @(posedge clk) begin
        if (!rst || !enable_count) begin
            edge_cnt <= '0;
            bit_cnt  <= BIT_CNT_W'(BIT_START);
        end else if (at_term) begin
            edge_cnt <= '0;
            bit_cnt  <= at_last ? BIT_CNT_W'(BIT_START) : bit_cnt + 1'b1;
        end else begin
            edge_cnt <= edge_cnt + 1'b1;
        end
    end

    if (DATA_BITS == 8) begin : g_frame_chk
        a_last_bit: assert property (@(posedge clk)
            last_bit == BIT_CNT_W'(PAR_EN ? BIT_STOP_P : BIT_STOP_NP));
    end
endmodule

// File: rtl/uart_rx_edge_sampler.sv
// UART RX oversampling front end: edge/bit counters plus mid-bit 3-sample majority vote.
// Vote visible at edge_cnt==MID+2 (3 cycles after first sample); no backpressure, FSM gates via enables.
module uart_rx_edge_sampler #(
    parameter int PRESCALE_W = uart_rx_pkg::PRESCALE_W,
    parameter int BIT_CNT_W  = uart_rx_pkg::BIT_CNT_W,
    parameter int DATA_BITS  = uart_rx_pkg::DATA_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] PRESCALE,
    input  logic                  PAR_EN,
    input  logic                  enable_count,
    input  logic                  dat_samp_en,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [BIT_CNT_W-1:0]  bit_cnt,
    output logic                  sampled_bit,
    output logic                  sample_valid
);
    import uart_rx_pkg::*;

    logic [PRESCALE_W-1:0] mid;
    logic                  at_s0;
    logic                  at_s1;
    logic                  at_s2;
    logic                  s0;
    logic                  s1;
    logic                  vote_ok;

    uart_rx_edge_bit_counter #(
        .PRESCALE_W (PRESCALE_W),
        .BIT_CNT_W  (BIT_CNT_W),
        .DATA_BITS  (DATA_BITS)
    ) u_counter (
        .clk          (clk),
        .rst          (rst),
        .enable_count (enable_count),
        .PAR_EN       (PAR_EN),
        .PRESCALE     (PRESCALE),
        .edge_cnt     (edge_cnt),
        .bit_cnt      (bit_cnt)
    );

    assign mid   = PRESCALE >> 1;
    assign at_s0 = (edge_cnt == mid - 1'b1);
    assign at_s1 = (edge_cnt == mid);
    assign at_s2 = (edge_cnt == mid + 1'b1);

    // vote_ok remembers that dat_samp_en stayed high across the earlier sample edges of this bit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s0           <= 1'b1;
            s1           <= 1'b1;
            vote_ok      <= 1'b0;
            sampled_bit  <= 1'b1;
            sample_valid <= 1'b0;
        end else if (!enable_count) begin
            s0           <= 1'b1;
            s1           <= 1'b1;
            vote_ok      <= 1'b0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (at_s0) begin
                vote_ok <= dat_samp_en;
                if (dat_samp_en) s0 <= RX_IN;
            end
            if (at_s1) begin
                vote_ok <= vote_ok & dat_samp_en;
                if (dat_samp_en) s1 <= RX_IN;
            end
            if (at_s2 && vote_ok && dat_samp_en) begin
                sampled_bit  <= maj3(s0, s1, RX_IN);
                sample_valid <= 1'b1;
            end
        end
    end

    a_valid_pulse: assert property (@(posedge clk) disable iff (!rst)
        sample_valid |=> !sample_valid);
endmodule

// File: tb/tb_uart_rx_edge_sampler.sv
// Randomized and directed bench for uart_rx_edge_sampler against a cycle-count reference model.
module tb_uart_rx_edge_sampler;
    localparam int PW   = 6;
    localparam int BW   = 4;
    localparam int DB   = 8;
    localparam int HMAX = 1024;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx;
    logic [PW-1:0] prescale;
    logic          par_en;
    logic          en;
    logic          dse;
    logic [PW-1:0] edge_cnt;
    logic [BW-1:0] bit_cnt;
    logic          sampled_bit;
    logic          sample_valid;

    always #5 clk = ~clk;

    uart_rx_edge_sampler dut (
        .clk          (clk),
        .rst          (rst),
        .RX_IN        (rx),
        .PRESCALE     (prescale),
        .PAR_EN       (par_en),
        .enable_count (en),
        .dat_samp_en  (dse),
        .edge_cnt     (edge_cnt),
        .bit_cnt      (bit_cnt),
        .sampled_bit  (sampled_bit),
        .sample_valid (sample_valid)
    );

    int   n_chk = 0;
    int   n_fail = 0;

    // Model: position is derived purely from how many enabled edges the current run has seen.
    int   run = 0;
    logic rx_hist [HMAX];
    logic ds_hist [HMAX];
    int   exp_edge = 0;
    int   exp_bit = 0;
    logic exp_sb = 1'b1;
    logic exp_sv = 1'b0;

    int   pulse_bit [$];
    logic pulse_val [$];
    int   pulse_edge [$];
    int   wraps = 0;
    int   prev_bit = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_update();
        int p, lb, mid, pos, base, ones;
        p   = int'(prescale);
        lb  = DB + 1 + int'(par_en);
        mid = p / 2;
        if (!rst) begin
            run = 0; exp_edge = 0; exp_bit = 0; exp_sb = 1'b1; exp_sv = 1'b0;
        end else if (!en) begin
            run = 0; exp_edge = 0; exp_bit = 0; exp_sv = 1'b0;
        end else begin
            if (run < HMAX) begin
                rx_hist[run] = rx;
                ds_hist[run] = dse;
            end
            pos    = run % p;
            exp_sv = 1'b0;
            if (pos == mid + 1 && run < HMAX) begin
                base = run - pos;
                if (ds_hist[base+mid-1] && ds_hist[base+mid] && ds_hist[base+mid+1]) begin
                    ones   = int'(rx_hist[base+mid-1]) + int'(rx_hist[base+mid]) + int'(rx_hist[base+mid+1]);
                    exp_sb = (ones >= 2);
                    exp_sv = 1'b1;
                end
            end
            run++;
            exp_edge = run % p;
            exp_bit  = (run / p) % (lb + 1);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
        chk("edge_cnt", 32'(edge_cnt), 32'(exp_edge));
        chk("bit_cnt", 32'(bit_cnt), 32'(exp_bit));
        chk("sampled_bit", 32'(sampled_bit), 32'(exp_sb));
        chk("sample_valid", 32'(sample_valid), 32'(exp_sv));
        if (sample_valid === 1'b1) begin
            pulse_bit.push_back(int'(bit_cnt));
            pulse_val.push_back(sampled_bit);
            pulse_edge.push_back(int'(edge_cnt));
        end
        if (rst && en && int'(bit_cnt) == 0 && prev_bit >= 9) wraps++;
        prev_bit = int'(bit_cnt);
    endtask

    task automatic clear_obs();
        pulse_bit.delete();
        pulse_val.delete();
        pulse_edge.delete();
        wraps = 0;
    endtask

    initial begin
        logic fr [11];
        logic exp_seq [11];
        logic [7:0] byte_v;
        logic bits6 [6];
        int   flip, max_e, max_b, n, cnt, found;
        logic sb_b4;

        rst = 1'b0; rx = 1'b1; prescale = PW'(8); par_en = 1'b0; en = 1'b0; dse = 1'b1;
        tick();
        tick();
        chk("rst_edge", 32'(edge_cnt), 32'd0);
        chk("rst_bit", 32'(bit_cnt), 32'd0);
        chk("rst_sb", 32'(sampled_bit), 32'd1);
        chk("rst_sv", 32'(sample_valid), 32'd0);
        rst = 1'b1;
        tick();

        // Free-running counters, PRESCALE=8, no parity.
        clear_obs(); en = 1'b1; max_e = 0; max_b = 0;
        for (int i = 0; i < 160; i++) begin
            tick();
            if (int'(edge_cnt) > max_e) max_e = int'(edge_cnt);
            if (int'(bit_cnt) > max_b) max_b = int'(bit_cnt);
        end
        chk("t2_max_edge", 32'(max_e), 32'd7);
        chk("t2_max_bit", 32'(max_b), 32'd9);
        chk("t2_wraps", 32'(wraps), 32'd2);
        chk("t2_end_bit", 32'(bit_cnt), 32'd0);

        // Majority of 1,0,1 then 0,1,0 in bit 2.
        for (int t = 0; t < 2; t++) begin
            en = 1'b0; tick();
            clear_obs(); en = 1'b1;
            for (int i = 0; i < 24; i++) begin
                rx = (t == 1);
                if (exp_bit == 2 && exp_edge == 3) rx = (t == 0);
                if (exp_bit == 2 && exp_edge == 4) rx = (t == 1);
                if (exp_bit == 2 && exp_edge == 5) rx = (t == 0);
                tick();
            end
            chk("t3_pulses", 32'(pulse_bit.size()), 32'd3);
            if (pulse_bit.size() == 3) begin
                chk("t3_vote", 32'(pulse_val[2]), (t == 0) ? 32'd1 : 32'd0);
                chk("t3_edge", 32'(pulse_edge[2]), 32'd6);
                chk("t3_bitidx", 32'(pulse_bit[2]), 32'd2);
            end
        end

        // 0xA5 with even parity at PRESCALE=16, one corrupted sample per bit.
        en = 1'b0; prescale = PW'(16); par_en = 1'b1; tick();
        byte_v = 8'hA5;
        fr[0] = 1'b0;
        for (int i = 0; i < 8; i++) fr[i+1] = byte_v[i];
        fr[9] = ^byte_v;
        fr[10] = 1'b1;
        exp_seq = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        clear_obs(); en = 1'b1; flip = 7;
        for (int i = 0; i < 176; i++) begin
            if (exp_edge == 0) flip = 7 + int'($urandom_range(0, 2));
            rx = fr[exp_bit] ^ (exp_edge == flip);
            tick();
        end
        chk("t4_pulses", 32'(pulse_val.size()), 32'd11);
        for (int i = 0; i < pulse_val.size() && i < 11; i++) begin
            chk("t4_bitval", 32'(pulse_val[i]), 32'(exp_seq[i]));
            chk("t4_edge", 32'(pulse_edge[i]), 32'd10);
        end
        chk("t4_wraps", 32'(wraps), 32'd1);

        // enable_count drops at bit 3 edge 5.
        en = 1'b0; prescale = PW'(8); par_en = 1'b0; tick();
        clear_obs(); en = 1'b1; found = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            rx = (exp_bit == 2);
            if (exp_bit == 3 && exp_edge == 5) found = 1;
            else tick();
        end
        chk("t5_reach", 32'(found), 32'd1);
        en = 1'b0; tick();
        chk("t5_edge", 32'(edge_cnt), 32'd0);
        chk("t5_bit", 32'(bit_cnt), 32'd0);
        chk("t5_sb", 32'(sampled_bit), 32'd1);
        chk("t5_sv", 32'(sample_valid), 32'd0);
        cnt = 0;
        foreach (pulse_bit[i]) if (pulse_bit[i] == 3) cnt++;
        chk("t5_b3_pulses", 32'(cnt), 32'd0);

        // Reset asserted between edges mid-frame.
        clear_obs(); en = 1'b1; rx = 1'b0; found = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            if (exp_bit == 4 && exp_edge == 2) found = 1;
            else tick();
        end
        chk("t6_reach", 32'(found), 32'd1);
        rst = 1'b0;
        #2;
        chk("t6_hold_edge", 32'(edge_cnt), 32'd2);
        chk("t6_hold_bit", 32'(bit_cnt), 32'd4);
        chk("t6_hold_sb", 32'(sampled_bit), 32'd0);
        tick();
        chk("t6_rst_edge", 32'(edge_cnt), 32'd0);
        chk("t6_rst_bit", 32'(bit_cnt), 32'd0);
        chk("t6_rst_sb", 32'(sampled_bit), 32'd1);
        chk("t6_rst_sv", 32'(sample_valid), 32'd0);
        rst = 1'b1;

        // dat_samp_en low only at MID of bit 4.
        en = 1'b0; tick();
        bits6 = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        clear_obs(); en = 1'b1; sb_b4 = 1'bx;
        for (int i = 0; i < 48; i++) begin
            rx  = bits6[exp_bit];
            dse = !(exp_bit == 4 && exp_edge == 4);
            tick();
            if (exp_bit == 4 && exp_edge == 7) sb_b4 = sampled_bit;
        end
        dse = 1'b1;
        chk("t7_sb_bit4", 32'(sb_b4), 32'd1);
        chk("t7_pulses", 32'(pulse_bit.size()), 32'd5);
        cnt = 0; found = 0;
        foreach (pulse_bit[i]) begin
            if (pulse_bit[i] == 4) cnt++;
            if (pulse_bit[i] == 5) begin
                found = 1;
                chk("t7_bit5_val", 32'(pulse_val[i]), 32'd0);
            end
        end
        chk("t7_b4_pulses", 32'(cnt), 32'd0);
        chk("t7_b5_seen", 32'(found), 32'd1);

        // Randomized segments across legal PRESCALE values.
        for (int s = 0; s < 60; s++) begin
            en = 1'b0; dse = 1'b1; rst = 1'b1; tick();
            prescale = PW'(2 * $urandom_range(4, 31));
            par_en   = 1'($urandom_range(0, 1));
            tick();
            n = int'($urandom_range(20, 600));
            for (int i = 0; i < n; i++) begin
                rx  = 1'($urandom_range(0, 1));
                dse = ($urandom_range(0, 9) != 0);
                en  = ($urandom_range(0, 199) != 0);
                rst = ($urandom_range(0, 499) != 0);
                tick();
            end
        end
        rst = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
